// File: rtl/stream_fifo_arbiter.sv
// Round-robin burst arbiter sharing one StreamingFIFO between NUM_IN AXI-Stream producers (STREAM_FIFO_ARBITER_STATS_EN adds counters).
// Latency: one arbitration cycle per grant, then a zero-cycle combinational data path.
// Backpressure: out_TREADY passes straight to the granted producer; a grant starts only when the FIFO has room for a full burst.
module stream_fifo_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int WIDTH        = 24,
    parameter int BURST        = 8,
    parameter int FIFO_DEPTH   = 16384,
    parameter int COUNT_W      = 15,
    parameter int IDLE_TIMEOUT = 16,
    localparam int GW          = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    ap_clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_TDATA,
    input  logic [NUM_IN-1:0]       in_TVALID,
    output logic [NUM_IN-1:0]       in_TREADY,
    output logic [WIDTH-1:0]        out_TDATA,
    output logic                    out_TVALID,
    input  logic                    out_TREADY,
    input  logic [COUNT_W-1:0]      fifo_count,
    output logic [GW-1:0]           grant_idx,
`ifdef STREAM_FIFO_ARBITER_STATS_EN
    output logic                    busy,
    output logic [NUM_IN*16-1:0]    grant_cnt,
    output logic [15:0]             timeout_cnt
`else
    output logic                    busy
`endif
);

    localparam int BW = $clog2(BURST + 1);
    localparam int IW = 8;
    localparam logic [COUNT_W:0] SPACE_LIM = (COUNT_W + 1)'(FIFO_DEPTH - BURST);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [GW-1:0]    r_last;
    logic [GW-1:0]    r_grant;
    logic [BW-1:0]    r_beat;
    logic [IW-1:0]    r_idle;

    logic             w_req_found;
    logic [GW-1:0]    w_req_idx;
    logic [GW-1:0]    w_scan;
    logic             w_space;
    logic             w_start;
    logic             w_gvld;
    logic [WIDTH-1:0] w_gdat;
    logic             w_acc;
    logic             w_last_beat;
    logic [IW-1:0]    w_idle_nxt;
    logic             w_timeout;

    // Scan starts one past the last grant so every requester waits at most NUM_IN-1 grants.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_scan      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_scan = GW'((int'(r_last) + k) % NUM_IN);
            if (!w_req_found && in_TVALID[w_scan]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_scan;
            end
        end
    end

    always_comb begin
        w_gvld    = 1'b0;
        w_gdat    = '0;
        in_TREADY = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (GW'(i) == r_grant) begin
                w_gvld       = in_TVALID[i];
                w_gdat       = in_TDATA[i*WIDTH +: WIDTH];
                in_TREADY[i] = (r_state == S_GRANT) && out_TREADY;
            end
        end
    end

    assign w_space     = ({1'b0, fifo_count} <= SPACE_LIM);
    assign w_start     = (r_state == S_IDLE) && w_req_found && w_space;
    assign w_acc       = (r_state == S_GRANT) && w_gvld && out_TREADY;
    assign w_last_beat = w_acc && (r_beat == BW'(BURST - 1));
    assign w_idle_nxt  = r_idle + 1'b1;
    // A stalled-but-valid producer is not idle; only a missing TVALID counts.
    assign w_timeout   = (r_state == S_GRANT) && !w_gvld && (w_idle_nxt == IW'(IDLE_TIMEOUT));

    assign out_TDATA  = w_gdat;
    assign out_TVALID = (r_state == S_GRANT) && w_gvld;
    assign busy       = (r_state == S_GRANT);
    assign grant_idx  = r_grant;

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= GW'(NUM_IN - 1);
            r_grant <= '0;
            r_beat  <= '0;
            r_idle  <= '0;
        end else if (w_start) begin
            r_state <= S_GRANT;
            r_grant <= w_req_idx;
            r_last  <= w_req_idx;
            r_beat  <= '0;
            r_idle  <= '0;
        end else if (r_state == S_GRANT) begin
            if (w_last_beat || w_timeout) begin
                r_state <= S_IDLE;
            end
            if (w_acc) begin
                r_beat <= r_beat + 1'b1;
            end
            r_idle <= w_gvld ? '0 : w_idle_nxt;
        end
    end

`ifdef STREAM_FIFO_ARBITER_STATS_EN
    logic [NUM_IN*16-1:0] r_grant_cnt;
    logic [15:0]          r_timeout_cnt;

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            r_grant_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_start && (w_req_idx == GW'(i)) && (r_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
        end
    end

    assign grant_cnt   = r_grant_cnt;
    assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Directed bench for stream_fifo_arbiter: NUM_IN=4, BURST=4, FIFO_DEPTH=16, IDLE_TIMEOUT=3.
// Producer i sends {i, sequence}; the bench tracks the expected sequence of each producer independently.
module tb_stream_fifo_arbiter;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int CW = 15;

    logic            ap_clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  in_TDATA;
    logic [N-1:0]    in_TVALID;
    logic [N-1:0]    in_TREADY;
    logic [W-1:0]    out_TDATA;
    logic            out_TVALID;
    logic            out_TREADY;
    logic [CW-1:0]   fifo_count;
    logic [1:0]      grant_idx;
    logic            busy;
`ifdef STREAM_FIFO_ARBITER_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     timeout_cnt;
`endif

    logic [15:0] seq     [N];
    logic [15:0] exp_seq [N];
    int n_chk = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    stream_fifo_arbiter #(
        .NUM_IN(N), .WIDTH(W), .BURST(4), .FIFO_DEPTH(16), .COUNT_W(CW), .IDLE_TIMEOUT(3)
    ) dut (
        .ap_clk(ap_clk),
        .reset(reset),
        .in_TDATA(in_TDATA),
        .in_TVALID(in_TVALID),
        .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA),
        .out_TVALID(out_TVALID),
        .out_TREADY(out_TREADY),
        .fifo_count(fifo_count),
        .grant_idx(grant_idx),
`ifdef STREAM_FIFO_ARBITER_STATS_EN
        .busy(busy),
        .grant_cnt(grant_cnt),
        .timeout_cnt(timeout_cnt)
`else
        .busy(busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) in_TDATA[i*W +: W] = {8'(i), seq[i]};
    endtask

    // Producers advance their sequence only on a real handshake at the edge.
    task automatic tick();
        logic [N-1:0] hs;
        hs = in_TVALID & in_TREADY;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i] = seq[i] + 16'd1;
        drive_data();
        #1;
    endtask

    task automatic check_beat(input int g);
        check("tready", 32'(in_TREADY), 32'(1 << g));
        check("tvalid", 32'(out_TVALID), 32'd1);
        check("tdata", 32'(out_TDATA), 32'({8'(g), exp_seq[g]}));
        check("grant_hold", 32'(grant_idx), 32'(g));
        exp_seq[g] = exp_seq[g] + 16'd1;
    endtask

    // From IDLE: one arbitration edge, four beats, then back in IDLE with grant_idx held.
    task automatic run_burst(input int g);
        tick();
        check("grant_idx", 32'(grant_idx), 32'(g));
        check("busy_on", 32'(busy), 32'd1);
        for (int b = 0; b < 4; b++) begin
            check_beat(g);
            tick();
        end
        check("busy_gap", 32'(busy), 32'd0);
        check("tready_gap", 32'(in_TREADY), 32'd0);
        check("grant_gap", 32'(grant_idx), 32'(g));
    endtask

    initial begin
        reset      = 1'b1;
        in_TVALID  = '0;
        out_TREADY = 1'b1;
        fifo_count = '0;
        for (int i = 0; i < N; i++) begin
            seq[i]     = '0;
            exp_seq[i] = '0;
        end
        drive_data();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tvalid", 32'(out_TVALID), 32'd0);
        check("rst_tready", 32'(in_TREADY), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);

        // Round robin with everyone requesting
        reset     = 1'b0;
        in_TVALID = 4'hF;
        run_burst(0);
        run_burst(1);
        run_burst(2);
        run_burst(3);
        run_burst(0);

        // Not enough room for a whole burst
        fifo_count = 15'd13;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("full_busy", 32'(busy), 32'd0);
            check("full_tready", 32'(in_TREADY), 32'd0);
            check("full_tvalid", 32'(out_TVALID), 32'd0);
        end
        fifo_count = 15'd12;
        run_burst(1);
        fifo_count = '0;

        // Producer 2 stalls after two beats
        tick();
        check("to_grant", 32'(grant_idx), 32'd2);
        check_beat(2);
        tick();
        check_beat(2);
        tick();
        in_TVALID = 4'b1011;
        #1;
        check("to_tvalid", 32'(out_TVALID), 32'd0);
        tick();
        check("to_busy1", 32'(busy), 32'd1);
        tick();
        check("to_busy2", 32'(busy), 32'd1);
        tick();
        check("to_busy3", 32'(busy), 32'd0);
        check("to_grant_held", 32'(grant_idx), 32'd2);
        in_TVALID = 4'hF;
        run_burst(3);

        // FIFO backpressure mid-burst must not time out
        tick();
        check("bp_grant", 32'(grant_idx), 32'd0);
        check_beat(0);
        tick();
        check_beat(0);
        tick();
        out_TREADY = 1'b0;
        #1;
        check("bp_tready", 32'(in_TREADY), 32'd0);
        check("bp_tvalid", 32'(out_TVALID), 32'd1);
        repeat (20) tick();
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_grant_held", 32'(grant_idx), 32'd0);
        out_TREADY = 1'b1;
        #1;
        check_beat(0);
        tick();
        check_beat(0);
        tick();
        check("bp_done", 32'(busy), 32'd0);

        // Reset during the second beat of a burst
        tick();
        check("rb_grant", 32'(grant_idx), 32'd1);
        check_beat(1);
        tick();
        check_beat(1);
        reset = 1'b1;
        tick();
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_tvalid", 32'(out_TVALID), 32'd0);
        check("rb_grant0", 32'(grant_idx), 32'd0);
        check("rb_tready", 32'(in_TREADY), 32'd0);
        reset = 1'b0;
        run_burst(0);

        // Ten grants per producer since reset, then one forced timeout on producer 0
        for (int n = 1; n < 40; n++) run_burst(n % 4);
        tick();
        check("ft_grant", 32'(grant_idx), 32'd0);
        in_TVALID = 4'b1110;
        repeat (3) tick();
        check("ft_busy", 32'(busy), 32'd0);
        in_TVALID = 4'hF;
`ifdef STREAM_FIFO_ARBITER_STATS_EN
        check("gcnt0", 32'(grant_cnt[15:0]), 32'd11);
        check("gcnt1", 32'(grant_cnt[31:16]), 32'd10);
        check("gcnt2", 32'(grant_cnt[47:32]), 32'd10);
        check("gcnt3", 32'(grant_cnt[63:48]), 32'd10);
        check("tocnt", 32'(timeout_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
